// File: rtl/sort_frame_sequencer_pkg.sv
// Shared widths and FSM encoding for the frame sort sequencer.
package sort_frame_sequencer_pkg;
    localparam int NETWORK_WIDTH = 8;
    localparam int INDEX_WIDTH   = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/sort_frame_sequencer_comparison_size_x.sv
// Combinational bitonic sorting network carrying an index tag with each value.
module comparison_size_x
    import sort_frame_sequencer_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DEPTH = $clog2(SIZE),
    parameter bit UP    = 1'b1
) (
    input  logic [SIZE-1:0][NETWORK_WIDTH-1:0] in_data,
    input  logic [SIZE-1:0][INDEX_WIDTH-1:0]   in_index,
    output logic [SIZE-1:0][NETWORK_WIDTH-1:0] out_data,
    output logic [SIZE-1:0][INDEX_WIDTH-1:0]   out_index
);

    logic [SIZE-1:0][NETWORK_WIDTH-1:0] d;
    logic [SIZE-1:0][INDEX_WIDTH-1:0]   x;
    logic [NETWORK_WIDTH-1:0]           td;
    logic [INDEX_WIDTH-1:0]             tx;
    logic [DEPTH-1:0]                   il;
    logic [DEPTH-1:0]                   ll;
    logic                               asc;
    logic                               swap;

    // Stage s merges bitonic runs of length 2<<s; partner distance halves each pass.
    always_comb begin
        d    = in_data;
        x    = in_index;
        td   = '0;
        tx   = '0;
        il   = '0;
        ll   = '0;
        asc  = 1'b0;
        swap = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            for (int t = s; t >= 0; t--) begin
                for (int i = 0; i < SIZE; i++) begin
                    if ((i ^ (1 << t)) > i) begin
                        il   = DEPTH'(i);
                        ll   = DEPTH'(i ^ (1 << t));
                        asc  = (((i & (2 << s)) == 0) == UP);
                        swap = asc ? (d[il] > d[ll]) : (d[il] < d[ll]);
                        if (swap) begin
                            td    = d[il];
                            d[il] = d[ll];
                            d[ll] = td;
                            tx    = x[il];
                            x[il] = x[ll];
                            x[ll] = tx;
                        end
                    end
                end
            end
        end
    end

    assign out_data  = d;
    assign out_index = x;

endmodule

// File: rtl/sort_frame_sequencer.sv
// Collects SIZE samples, sorts them in one cycle, then streams them out in order
// together with each sample's arrival slot.
module sort_frame_sequencer
    import sort_frame_sequencer_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NETWORK_WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NETWORK_WIDTH-1:0] out_data,
    output logic [INDEX_WIDTH-1:0]   out_index,
    output logic                     out_last,
    output logic                     busy
);

    localparam int CW = $clog2(SIZE);

    state_e                   state_q, state_d;
    logic [CW-1:0]            wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]            rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]            rd_nxt;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic [NETWORK_WIDTH-1:0] out_data_q, out_data_d;
    logic [INDEX_WIDTH-1:0]   out_index_q, out_index_d;
    logic                     in_fire;
    logic                     out_fire;

    logic [SIZE-1:0][NETWORK_WIDTH-1:0] ibuf_data_q, ibuf_data_d;
    logic [SIZE-1:0][INDEX_WIDTH-1:0]   ibuf_idx_q, ibuf_idx_d;
    logic [SIZE-1:0][NETWORK_WIDTH-1:0] obuf_data_q, obuf_data_d;
    logic [SIZE-1:0][INDEX_WIDTH-1:0]   obuf_idx_q, obuf_idx_d;
    logic [SIZE-1:0][NETWORK_WIDTH-1:0] srt_data;
    logic [SIZE-1:0][INDEX_WIDTH-1:0]   srt_idx;

    // Sorter emits in drain order directly, so rd_cnt indexes it one-to-one.
    comparison_size_x #(
        .SIZE  (SIZE),
        .DEPTH (CW),
        .UP    (!DESCEND)
    ) u_sorter (
        .in_data   (ibuf_data_q),
        .in_index  (ibuf_idx_q),
        .out_data  (srt_data),
        .out_index (srt_idx)
    );

    assign in_fire  = in_valid && in_ready_q && (state_q == FILL);
    assign out_fire = out_valid_q && out_ready && (state_q == DRAIN);
    assign rd_nxt   = rd_cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        ibuf_data_d = ibuf_data_q;
        ibuf_idx_d  = ibuf_idx_q;
        obuf_data_d = obuf_data_q;
        obuf_idx_d  = obuf_idx_q;
        if (clear) begin
            state_d     = FILL;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            out_index_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    in_ready_d = 1'b1;
                    if (in_fire) begin
                        ibuf_data_d[wr_cnt_q] = in_data;
                        ibuf_idx_d[wr_cnt_q]  = INDEX_WIDTH'(wr_cnt_q);
                        if (wr_cnt_q == CW'(SIZE - 1)) begin
                            state_d    = SORT;
                            wr_cnt_d   = '0;
                            in_ready_d = 1'b0;
                        end else begin
                            wr_cnt_d = wr_cnt_q + CW'(1);
                        end
                    end
                end
                SORT: begin
                    obuf_data_d = srt_data;
                    obuf_idx_d  = srt_idx;
                    out_data_d  = srt_data[0];
                    out_index_d = srt_idx[0];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    in_ready_d  = 1'b0;
                    state_d     = DRAIN;
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (rd_cnt_q == CW'(SIZE - 1)) begin
                            state_d     = FILL;
                            rd_cnt_d    = '0;
                            in_ready_d  = 1'b1;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            out_data_d  = '0;
                            out_index_d = '0;
                        end else begin
                            rd_cnt_d    = rd_nxt;
                            out_data_d  = obuf_data_q[rd_nxt];
                            out_index_d = obuf_idx_q[rd_nxt];
                            out_last_d  = (rd_nxt == CW'(SIZE - 1));
                        end
                    end
                end
                default: begin
                    state_d    = FILL;
                    in_ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
        end
    end

    // Frame storage is fully qualified by the FSM, so it carries no reset.
    always_ff @(posedge clk) begin
        ibuf_data_q <= ibuf_data_d;
        ibuf_idx_q  <= ibuf_idx_d;
        obuf_data_q <= obuf_data_d;
        obuf_idx_q  <= obuf_idx_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign busy      = !((state_q == FILL) && (wr_cnt_q == '0));

endmodule
